// File: rtl/proc19_pkg.sv
// Shared widths, issue bundle and decode helper for the 19-bit operand fetch stage.
package proc19_pkg;

  localparam int unsigned DATA_W = 19;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned CTRL_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic              use_rs1;
    logic              use_rs2;
    logic              wr_rd;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] imm;
  } issue_t;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [ADDR_W-1:0] addr);
    logic [NREGS-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/op_scoreboard.sv
// Busy-bit scoreboard: one bit per register with an outstanding write.
// OPFETCH_WB_BYPASS_EN lets a same-cycle writeback release the hazard.
module op_scoreboard
  import proc19_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              fl_en,
  input  logic [ADDR_W-1:0] fl_addr,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  output logic              blk_rs1,
  output logic              blk_rs2,
  output logic              blk_rd
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] clr;
  logic [NREGS-1:0] fl_clr;
  logic [NREGS-1:0] set;
  logic [NREGS-1:0] blk;

  always_comb begin
    clr    = clr_en ? reg_onehot(clr_addr) : '0;
    fl_clr = fl_en  ? reg_onehot(fl_addr)  : '0;
    set    = set_en ? reg_onehot(set_addr) : '0;
    // Set is OR-ed last so it wins over a same-edge clear.
    busy_d = (busy_q & ~clr & ~fl_clr) | set;
`ifdef OPFETCH_WB_BYPASS_EN
    blk    = busy_q & ~clr;
`else
    blk    = busy_q;
`endif
    blk_rs1 = blk[rs1];
    blk_rs2 = blk[rs2];
    blk_rd  = blk[rd];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch / issue stage: hazard stall, operand capture and output pipeline register.
// Define OPFETCH_WB_BYPASS_EN for same-cycle writeback forwarding.
module operand_fetch_stage
  import proc19_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic              in_wr_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_imm,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wr_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_imm
);

  issue_t            issue;
  logic              blk_rs1;
  logic              blk_rs2;
  logic              blk_rd;
  logic              hz;
  logic              accept;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  assign issue = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, use_rs1: in_use_rs1,
                   use_rs2: in_use_rs2, wr_rd: in_wr_rd, ctrl: in_ctrl, imm: in_imm};

  assign rf_raddr1 = issue.rs1;
  assign rf_raddr2 = issue.rs2;

  op_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept && issue.wr_rd),
    .set_addr (issue.rd),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .fl_en    (flush && out_valid && out_wr_rd),
    .fl_addr  (out_rd),
    .rs1      (issue.rs1),
    .rs2      (issue.rs2),
    .rd       (issue.rd),
    .blk_rs1  (blk_rs1),
    .blk_rs2  (blk_rs2),
    .blk_rd   (blk_rd)
  );

  always_comb begin
    hz       = (issue.use_rs1 && blk_rs1) || (issue.use_rs2 && blk_rs2) ||
               (issue.wr_rd && blk_rd);
    in_ready = (!out_valid || out_ready) && !hz && !flush;
    accept   = in_valid && in_ready;
`ifdef OPFETCH_WB_BYPASS_EN
    op1 = (wb_en && (wb_addr == issue.rs1)) ? wb_data : rf_rdata1;
    op2 = (wb_en && (wb_addr == issue.rs2)) ? wb_data : rf_rdata2;
`else
    op1 = rf_rdata1;
    op2 = rf_rdata2;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_rd    <= '0;
      out_wr_rd <= 1'b0;
      out_ctrl  <= '0;
      out_imm   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op1   <= op1;
      out_op2   <= op2;
      out_rd    <= issue.rd;
      out_wr_rd <= issue.wr_rd;
      out_ctrl  <= issue.ctrl;
      out_imm   <= issue.imm;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
